// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the EX-stage ALU. It holds the 4-bit ALU control
//   codes, which the ALU decoder also uses, the default datapath width, the
//   FSM state encoding, and the internal shift-kind encoding.
//   It has no ports.
package alu_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exState_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shiftKind_e;

    function automatic logic isShiftCode(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

    function automatic shiftKind_e toShiftKind(input logic [3:0] ctrl);
        case (ctrl)
            ALU_SRL: return SH_SRL;
            ALU_SRA: return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
//   This interface carries the issue and result handshakes of the EX unit.
//   Signal suffixes are named from the point of view of the execution unit.
//   The slave modport is the execution unit. The master modport is the
//   pipeline side, meaning the issuer and the downstream consumer.
//     valid_i/ready_o        : issue handshake
//     ctrl_i/src1_i/src2_i   : operation and operands
//     valid_o/ready_i        : result handshake
//     result_o/zero_o        : registered result and zero flag
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [3:0]      ctrl_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;

    modport master (
        output valid_i, ctrl_i, src1_i, src2_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o
    );

    modport slave (
        input  valid_i, ctrl_i, src1_i, src2_i, ready_i,
        output ready_o, valid_o, result_o, zero_o
    );
endinterface

// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter
//   This is an iterative barrel-lite shifter. It moves at most SHIFT_STEP bit
//   positions per cycle until the remaining shift amount reaches zero.
//     clk_i, rst_i : clock and synchronous active-high reset
//     clear_i      : drops any shift in progress (flush)
//     load_i       : starts a new shift of value_i by shamt_i of kind kind_i
//     done_o       : high in the cycle whose step finishes the shift
//     result_o     : value after this cycle's step, valid when done_o is high
module alu_iter_shifter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int SHIFT_STEP = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  shiftKind_e               kind_i,
    input  logic [XLEN-1:0]          value_i,
    input  logic [$clog2(XLEN)-1:0]  shamt_i,
    output logic                     done_o,
    output logic [XLEN-1:0]          result_o
);
    localparam int SHW = $clog2(XLEN);
    // STEP_W is one bit wider than rem so that SHIFT_STEP == XLEN still fits.
    localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  rem_q, rem_d;
    shiftKind_e      kind_q, kind_d;
    logic [SHW-1:0]  step;
    logic [XLEN-1:0] shifted;

    // step = min(SHIFT_STEP, rem). The truncated STEP_W is only selected when
    // rem >= SHIFT_STEP, so it always fits.
    always_comb begin
        step = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[SHW-1:0];
        case (kind_q)
            SH_SRL:  shifted = work_q >> step;
            SH_SRA:  shifted = $signed(work_q) >>> step;
            default: shifted = work_q << step;
        endcase
    end

    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        kind_d = kind_q;
        if (load_i) begin
            work_d = value_i;
            rem_d  = shamt_i;
            kind_d = kind_i;
        end else if (rem_q != '0) begin
            work_d = shifted;
            rem_d  = rem_q - step;
        end
    end

    assign done_o   = (rem_q != '0) && ({1'b0, rem_q} <= STEP_W);
    assign result_o = shifted;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_q <= '0;
            rem_q  <= '0;
            kind_q <= SH_SLL;
        end else if (clear_i) begin
            rem_q  <= '0;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            kind_q <= kind_d;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   This is the multi-cycle EX-stage ALU. Logic, arithmetic and SLT
//   operations complete in one registered cycle. Shifts with a nonzero
//   amount iterate in alu_iter_shifter.
//     clk_i, rst_i : clock and synchronous active-high reset
//     flush_i      : discards the in-flight op and the op offered this cycle
//     busy_o       : high while a shift is iterating
//     bus          : issue/result handshake (alu_exec_unit_if.slave)
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    output logic            busy_o,
    alu_exec_unit_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    exState_e        state_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    logic            accept;
    logic            startShift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] aluResult;
    logic            shDone;
    logic [XLEN-1:0] shResult;

    // DONE can take a new op only while its result is being taken downstream.
    // Without this rule the held result would be overwritten.
    assign bus.ready_o = ~rst_i & ((state_q == IDLE) | ((state_q == DONE) & bus.ready_i));
    assign accept      = bus.valid_i & bus.ready_o & ~flush_i;
    assign shamt       = bus.src2_i[SHW-1:0];
    assign startShift  = accept & isShiftCode(bus.ctrl_i) & (shamt != '0);

    // One-cycle unit. A shift by zero passes src1 through unchanged.
    always_comb begin
        aluResult = bus.src1_i + bus.src2_i;
        case (bus.ctrl_i)
            ALU_SUB: aluResult = bus.src1_i - bus.src2_i;
            ALU_AND: aluResult = bus.src1_i & bus.src2_i;
            ALU_OR:  aluResult = bus.src1_i | bus.src2_i;
            ALU_XOR: aluResult = bus.src1_i ^ bus.src2_i;
            ALU_SLT: aluResult = {{(XLEN-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            ALU_SLL, ALU_SRL, ALU_SRA: aluResult = bus.src1_i;
            default: aluResult = bus.src1_i + bus.src2_i;
        endcase
    end

    alu_iter_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (flush_i),
        .load_i   (startShift),
        .kind_i   (toShiftKind(bus.ctrl_i)),
        .value_i  (bus.src1_i),
        .shamt_i  (shamt),
        .done_o   (shDone),
        .result_o (shResult)
    );

    // Flush takes priority over accept and handshake. It leaves result_q
    // untouched, so the last completed result stays visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (flush_i) begin
            state_q  <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (startShift) begin
                            state_q <= SHIFT;
                        end else begin
                            result_q <= aluResult;
                            zero_q   <= (aluResult == '0);
                            state_q  <= DONE;
                        end
                    end else if ((state_q == DONE) && bus.ready_i) begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (shDone) begin
                        result_q <= shResult;
                        zero_q   <= (shResult == '0);
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.valid_o  = (state_q == DONE);
    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign busy_o       = (state_q == SHIFT);
endmodule
